add_sub: RTL and testbench
==========================

ADD_SUB -- requirements
Module: add_sub

Interface
REQ-001 The block SHALL have parameter W, default 16, giving the width of each signed complex component.
REQ-002 The block SHALL have parameter SATURATE, default 0: 0 = two's-complement wrap, 1 = clamp to the signed W-bit range.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  a, b and op are sampled this cycle.
REQ-007 a  input  2W  complex operand, Re in [2W-1:W], Im in [W-1:0], both signed two's complement.
REQ-008 b  input  2W  complex operand, same packing as a.
REQ-009 op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-010 out_valid  output  1  c and the flags hold a new result.
REQ-011 c  output  2W  complex result, same packing as a.
REQ-012 ovf_re  output  1  the real-part exact result fell outside the signed W-bit range.
REQ-013 ovf_im  output  1  the imaginary-part exact result fell outside the signed W-bit range.

Function
REQ-014 Re(c) SHALL be Re(a) + Re(b) when op=0, and Re(a) - Re(b) when op=1; Im(c) SHALL follow the same rule independently.
REQ-015 Each component SHALL be computed exactly at W+1 bits, then reduced to W bits: wrap (low W bits) when SATURATE=0; when SATURATE=1, clamp to 2^(W-1)-1 on positive overflow and -2^(W-1) on negative overflow.
REQ-016 ovf_re/ovf_im SHALL be asserted whenever the exact W+1-bit result is outside the W-bit range, in either SATURATE mode.
REQ-017 Latency SHALL be exactly one cycle: inputs sampled at edge N with in_valid=1 appear on c/flags with out_valid=1 after edge N.
REQ-018 There SHALL be no back-pressure; a new operation SHALL be accepted every cycle.
REQ-019 When in_valid=0 at an edge, out_valid SHALL be 0 after that edge, and c/ovf_* SHALL hold their previous values.
REQ-020 Subtraction of -2^(W-1) SHALL be handled by the W+1-bit exact path, for example 0 - (-32768) with W=16: wrap gives -32768 with ovf=1; saturate gives 32767 with ovf=1.
REQ-021 The outputs SHALL be driven directly from registers, with no combinational input-to-output path.

Reset
REQ-022 With rst=1 at a rising edge, out_valid, c, ovf_re and ovf_im SHALL all be 0 after that edge.
REQ-023 rst SHALL take priority over a simultaneous in_valid, and the operation presented in that cycle SHALL be discarded.
REQ-024 The first operation accepted after rst deasserts SHALL complete normally with one-cycle latency.

Structure
REQ-025 A shared package SHALL hold: the complex packing helpers (Re/Im slice positions, signed views), the W default, and the op encodings ADD=0 and SUB=1.
REQ-026 One sub-module, addsub_lane, SHALL implement the per-component signed add/subtract, overflow detection and wrap/saturate logic, and SHALL be instantiated twice (Re and Im).
REQ-027 The top level SHALL contain only packing and unpacking, the two lanes, and the output register stage.

Verification (W=16, SATURATE=0 unless stated)
REQ-028 op=1, a=(-11,15), b=(13,-14) -> c=(-24,29), ovf_re=ovf_im=0, one cycle later.
REQ-029 op=0, a=(14,3), b=(21,-64) -> c=(35,-61); then op=0, a=(20,18), b=(-40,32) -> c=(-20,50), issued back to back on consecutive cycles.
REQ-030 op=1, a=(43,0), b=(-1,-37) -> c=(44,37), ovf=0.
REQ-031 op=0, a=(32767,-32768), b=(1,-1) -> c=(-32768,32767), ovf_re=ovf_im=1; with SATURATE=1 -> c=(32767,-32768), ovf_re=ovf_im=1.
REQ-032 rst asserted while in_valid=1 -> out_valid=0 and c=0 after the edge; an idle cycle (in_valid=0) -> out_valid=0 and c holds its previous value.

Source files
------------

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared types, encodings and complex packing helpers for add_sub
//
// Contents:
//   W_DEFAULT          default width of one signed complex component
//   op_e               operation encodings (OP_ADD = 0, OP_SUB = 1)
//   re_msb/re_lsb      bit positions of the real part in a packed 2W-bit word
//   im_msb/im_lsb      bit positions of the imaginary part in a packed 2W-bit word
//   re_of/im_of        signed views of the components of a default-width packed word
//   pack_cx            builds a default-width packed word from two signed components

package add_sub_pkg;

    localparam int W_DEFAULT = 16;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Packing: Re occupies the upper half, Im the lower half.
    function automatic int re_msb(input int w);
        return 2 * w - 1;
    endfunction

    function automatic int re_lsb(input int w);
        return w;
    endfunction

    function automatic int im_msb(input int w);
        return w - 1;
    endfunction

    function automatic int im_lsb(input int w);
        return 0;
    endfunction

    function automatic logic signed [W_DEFAULT-1:0] re_of(input logic [2*W_DEFAULT-1:0] v);
        return $signed(v[2*W_DEFAULT-1:W_DEFAULT]);
    endfunction

    function automatic logic signed [W_DEFAULT-1:0] im_of(input logic [2*W_DEFAULT-1:0] v);
        return $signed(v[W_DEFAULT-1:0]);
    endfunction

    function automatic logic [2*W_DEFAULT-1:0] pack_cx(input logic signed [W_DEFAULT-1:0] re,
                                                       input logic signed [W_DEFAULT-1:0] im);
        return {re, im};
    endfunction

endpackage

// File: rtl/addsub_lane.sv
// rtl/addsub_lane.sv - one signed component add/subtract with overflow detect and wrap/saturate
//
// Ports:
//   a, b   W-bit signed operands (two's complement)
//   op     OP_ADD: a+b, OP_SUB: a-b
//   y      W-bit result, wrapped or clamped depending on SATURATE
//   ovf    exact result lies outside the signed W-bit range

module addsub_lane
    import add_sub_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter bit SATURATE = 1'b0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic [W-1:0] y,
    output logic         ovf
);

    localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] NEG_MIN = {1'b1, {(W-1){1'b0}}};

    // One extra bit of headroom makes the result exact, including
    // subtraction of the most negative value.
    logic [W:0] a_x;
    logic [W:0] b_x;
    logic [W:0] exact;

    assign a_x   = {a[W-1], a};
    assign b_x   = {b[W-1], b};
    assign exact = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);

    // The exact value fits in W bits only when the top two bits agree.
    assign ovf = exact[W] ^ exact[W-1];

    always_comb begin
        y = exact[W-1:0];
        if (SATURATE && ovf) begin
            // exact[W] is the true sign of the unreduced result.
            y = exact[W] ? NEG_MIN : POS_MAX;
        end
    end

endmodule

// File: rtl/add_sub.sv
// rtl/add_sub.sv - complex add/subtract with one-cycle registered result
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   a, b and op are sampled this cycle
//   a, b       2W-bit complex operands, Re in [2W-1:W], Im in [W-1:0]
//   op         0 = add, 1 = subtract
//   out_valid  c and the overflow flags carry a new result
//   c          2W-bit complex result, same packing as a
//   ovf_re     real-part exact result outside the signed W-bit range
//   ovf_im     imaginary-part exact result outside the signed W-bit range

module add_sub
    import add_sub_pkg::*;
#(
    parameter int W        = W_DEFAULT,
    parameter int SATURATE = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
    input  logic           op,
    output logic           out_valid,
    output logic [2*W-1:0] c,
    output logic           ovf_re,
    output logic           ovf_im
);

    localparam int RE_MSB = re_msb(W);
    localparam int RE_LSB = re_lsb(W);
    localparam int IM_MSB = im_msb(W);
    localparam int IM_LSB = im_lsb(W);
    localparam bit SAT    = (SATURATE != 0);

    logic [W-1:0] re_y;
    logic [W-1:0] im_y;
    logic         re_ovf;
    logic         im_ovf;

    addsub_lane #(
        .W        (W),
        .SATURATE (SAT)
    ) u_lane_re (
        .a   (a[RE_MSB:RE_LSB]),
        .b   (b[RE_MSB:RE_LSB]),
        .op  (op),
        .y   (re_y),
        .ovf (re_ovf)
    );

    addsub_lane #(
        .W        (W),
        .SATURATE (SAT)
    ) u_lane_im (
        .a   (a[IM_MSB:IM_LSB]),
        .b   (b[IM_MSB:IM_LSB]),
        .op  (op),
        .y   (im_y),
        .ovf (im_ovf)
    );

    // Result and flags only update on accepted operations; idle cycles
    // drop out_valid but leave the last result visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            c         <= '0;
            ovf_re    <= 1'b0;
            ovf_im    <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                c      <= {re_y, im_y};
                ovf_re <= re_ovf;
                ovf_im <= im_ovf;
            end
        end
    end

endmodule

// File: tb/tb_add_sub.sv
// tb/tb_add_sub.sv - directed self-checking bench for add_sub in wrap and saturate modes

module tb_add_sub;
    import add_sub_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        op;

    logic        w_out_valid, s_out_valid;
    logic [31:0] w_c, s_c;
    logic        w_ovf_re, w_ovf_im, s_ovf_re, s_ovf_im;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    add_sub #(.W(16), .SATURATE(0)) u_wrap (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (w_out_valid),
        .c         (w_c),
        .ovf_re    (w_ovf_re),
        .ovf_im    (w_ovf_im)
    );

    add_sub #(.W(16), .SATURATE(1)) u_sat (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (s_out_valid),
        .c         (s_c),
        .ovf_re    (s_ovf_re),
        .ovf_im    (s_ovf_im)
    );

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] r;
        logic [31:0] i;
        r = re;
        i = im;
        return {r[15:0], i[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present inputs just after a falling edge, let one rising edge pass,
    // then return at the next falling edge where outputs are stable.
    task automatic step(input logic r, input logic v, input logic [31:0] av,
                        input logic [31:0] bv, input logic o);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        op       = o;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = 1'b0;
        @(negedge clk);

        // Reset with a valid operation present: operation discarded.
        step(1'b1, 1'b1, cx(100, 200), cx(5, 6), 1'b0);
        chk("rst_wrap_valid", {31'd0, w_out_valid}, 32'd0);
        chk("rst_wrap_c",     w_c, 32'd0);
        chk("rst_wrap_ovf",   {30'd0, w_ovf_re, w_ovf_im}, 32'd0);
        chk("rst_sat_valid",  {31'd0, s_out_valid}, 32'd0);
        chk("rst_sat_c",      s_c, 32'd0);

        // (-11,15) - (13,-14) = (-24,29)
        step(1'b0, 1'b1, cx(-11, 15), cx(13, -14), OP_SUB);
        chk("sub1_valid", {31'd0, w_out_valid}, 32'd1);
        chk("sub1_c",     w_c, cx(-24, 29));
        chk("sub1_ovf",   {30'd0, w_ovf_re, w_ovf_im}, 32'd0);
        chk("sub1_sat_c", s_c, cx(-24, 29));

        // Back to back adds on consecutive cycles.
        step(1'b0, 1'b1, cx(14, 3), cx(21, -64), OP_ADD);
        chk("add1_valid", {31'd0, w_out_valid}, 32'd1);
        chk("add1_c",     w_c, cx(35, -61));
        step(1'b0, 1'b1, cx(20, 18), cx(-40, 32), OP_ADD);
        chk("add2_valid", {31'd0, w_out_valid}, 32'd1);
        chk("add2_c",     w_c, cx(-20, 50));

        // (43,0) - (-1,-37) = (44,37)
        step(1'b0, 1'b1, cx(43, 0), cx(-1, -37), OP_SUB);
        chk("sub2_c",   w_c, cx(44, 37));
        chk("sub2_ovf", {30'd0, w_ovf_re, w_ovf_im}, 32'd0);

        // Range extremes that just fit.
        step(1'b0, 1'b1, cx(-32768, 32767), cx(0, 0), OP_ADD);
        chk("edge_fit_c",   s_c, cx(-32768, 32767));
        chk("edge_fit_ovf", {30'd0, s_ovf_re, s_ovf_im}, 32'd0);

        // (32767,-32768) + (1,-1): positive and negative overflow.
        step(1'b0, 1'b1, cx(32767, -32768), cx(1, -1), OP_ADD);
        chk("ovf_add_wrap_c",   w_c, cx(-32768, 32767));
        chk("ovf_add_wrap_ovf", {30'd0, w_ovf_re, w_ovf_im}, 32'd3);
        chk("ovf_add_sat_c",    s_c, cx(32767, -32768));
        chk("ovf_add_sat_ovf",  {30'd0, s_ovf_re, s_ovf_im}, 32'd3);

        // (0,-32768) - (-32768,1): Re exact 32768, Im exact -32769.
        step(1'b0, 1'b1, cx(0, -32768), cx(-32768, 1), OP_SUB);
        chk("ovf_sub_wrap_c",   w_c, cx(-32768, 32767));
        chk("ovf_sub_wrap_ovf", {30'd0, w_ovf_re, w_ovf_im}, 32'd3);
        chk("ovf_sub_sat_c",    s_c, cx(32767, -32768));
        chk("ovf_sub_sat_ovf",  {30'd0, s_ovf_re, s_ovf_im}, 32'd3);

        // Idle cycle: out_valid drops, result and flags hold.
        step(1'b0, 1'b0, cx(1, 1), cx(1, 1), OP_ADD);
        chk("idle_valid", {31'd0, w_out_valid}, 32'd0);
        chk("idle_c",     w_c, cx(-32768, 32767));
        chk("idle_ovf",   {30'd0, w_ovf_re, w_ovf_im}, 32'd3);
        chk("idle_sat_c", s_c, cx(32767, -32768));

        // Reset again while a valid operation is presented.
        step(1'b1, 1'b1, cx(7, 7), cx(7, 7), OP_ADD);
        chk("rst2_valid", {31'd0, w_out_valid}, 32'd0);
        chk("rst2_c",     w_c, 32'd0);
        chk("rst2_ovf",   {30'd0, w_ovf_re, w_ovf_im}, 32'd0);

        // First operation after reset completes with one-cycle latency.
        step(1'b0, 1'b1, cx(-5, 100), cx(-7, -300), OP_ADD);
        chk("post_rst_valid", {31'd0, w_out_valid}, 32'd1);
        chk("post_rst_c",     w_c, cx(-12, -200));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
